muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencing controller between the CPU execute stage and the iterative multiply/divide engines. It accepts one MULT or DIV request at a time and latches the operands. It then sequences the divider's clear/start/finish protocol or the multiplier's start/finish protocol, applies sign correction and divide-by-zero handling, and owns the architectural HI/LO registers. While an operation is in flight it drives `busy` so the pipeline stalls.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in engine-run cycles (used only with `MULDIV_TIMEOUT_EN`).
- `clock` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `req` in 1: operation request, sampled only in IDLE.
- `op_div` in 1: 1 = signed DIV, 0 = signed MULT.
- `rs_val` in 32: dividend / multiplicand.
- `rt_val` in 32: divisor / multiplier.
- `wr_hi`, `wr_lo` in 1 each: MTHI/MTLO strobes, honoured only in IDLE.
- `wdata` in 32: MTHI/MTLO data.
- `div_clear` out 1: one-cycle pulse to the divider's reset input.
- `div_start` out 1: divider start level.
- `div_done` in 1: divider finish flag.
- `div_quot`, `div_rem` in 32 each: divider magnitude results.
- `mult_start` out 1: multiplier start level.
- `mult_done` in 1: multiplier finish flag.
- `mult_hi`, `mult_lo` in 32 each: multiplier product halves.
- `busy` out 1: stall request to the pipeline.
- `done` out 1: one-cycle completion pulse.
- `div_zero` out 1: divide-by-zero flag.
- `timeout` out 1: watchdog error flag (tied 0 without the macro).
- `hi`, `lo` out 32 each: architectural HI/LO registers.

## Operation
- States: IDLE, DCLR, DRUN, MRUN, DONE.
- IDLE, `req`=0: `wr_hi`/`wr_lo` load `wdata` into `hi`/`lo`.
- IDLE, `req`=1: latch `rs_val`, `rt_val`, `op_div`, and the sign bits s_a = rs[31], s_b = rt[31]. Clear `div_zero` and `timeout`.
  - DIV with `rt_val`==0 → DONE. Set `div_zero`=1. `hi`/`lo` unchanged. No engine activity.
  - DIV with `rt_val`≠0 → DCLR.
  - MULT → MRUN.
- IDLE, `req` and `wr_hi`/`wr_lo` together: the write is performed, and the operation result later overwrites it.
- DCLR: `div_clear`=1 for exactly one cycle → DRUN.
- DRUN: `div_start`=1.
  - On a cycle with `div_done`=1: `lo` ← (s_a^s_b) ? −div_quot : div_quot; `hi` ← s_a ? −div_rem : div_rem → DONE.
  - Arithmetic is 32-bit two's complement with wrap. 0x80000000 / −1 gives `lo`=0x80000000, `hi`=0.
- MRUN: `mult_start`=1.
  - On `mult_done`=1: `hi` ← mult_hi, `lo` ← mult_lo → DONE. The multiplier handles its own signs.
- DONE: `done`=1 for one cycle → IDLE.
- `req` outside IDLE is ignored; the requester holds it until it sees `busy`=0.
- `wr_hi`/`wr_lo` outside IDLE are ignored.
- `div_zero` and `timeout` are sticky until the next accepted `req` or `reset`.
- `reset` in any state, including mid-DRUN: next state IDLE, `div_clear`=1 for that one cycle so the engine is also flushed, all other outputs at reset values.

## Timing
- Reset values: `hi`=`lo`=0; `busy`=`done`=`div_zero`=`timeout`=0; `div_start`=`mult_start`=0; `div_clear`=1 during the reset cycle only.
- Request accepted at edge of cycle T. `busy`=1 from T+1 through the last DRUN/MRUN cycle. `busy`=0 in the DONE cycle.
- Divide-by-zero: DONE at T+1. `done`=1, `div_zero`=1, `busy`=0 at T+1.
- DIV: `div_clear` at T+1. `div_start`=1 from T+2. With `div_done` sampled high in cycle D:
  - `div_start` falls at D+1, so the engine is never restarted.
  - `hi`/`lo` are updated and `done`=1 at D+1.
  - Nominal divider: D = T+35, so `done` at T+36.
- MULT: `mult_start` from T+1. `mult_done` in cycle M → `done` and new `hi`/`lo` at M+1.
- Back-to-back: the earliest next acceptance is the cycle after DONE.

## Configuration
- `MULDIV_TIMEOUT_EN` defined:
  - A 7-bit run counter clears on entry to DRUN/MRUN and increments each run cycle.
  - If it reaches `TIMEOUT_CYCLES` without a done flag: drop the start level, pulse `div_clear` (for DIV), set `timeout`=1, leave `hi`/`lo` unchanged → DONE.
- Undefined: no counter. DRUN/MRUN wait indefinitely. `timeout` is tied to 0.

## Test plan
- Reset, then MTHI 0x1234 and MTLO 0x5678 in IDLE → `hi`=0x00001234, `lo`=0x00005678. MTHI while `busy` → `hi` unchanged.
- DIV −7 / 2 with the real divider model → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). `done` is a single pulse at T+36. `div_start` is low the cycle after `div_done`.
- DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIV 100 / 0 → `done` at T+1, `div_zero`=1, `hi`/`lo` unchanged, `div_clear`/`div_start` never asserted.
- MULT with stub engine returning `mult_done` 5 cycles after start, `mult_hi`=0xFFFFFFFF, `mult_lo`=0xFFFFFFFA → `busy` for 5 cycles, then `hi`/`lo` match the stub values.
- `reset` asserted mid-DRUN → next cycle IDLE, `div_clear`=1, `busy`=0, `hi`=`lo`=0. A new DIV 9/3 then completes with `lo`=3, `hi`=0.
- With `MULDIV_TIMEOUT_EN`, stub divider never asserts done → `timeout`=1 and `done`=1 after 64 DRUN cycles, `hi`/`lo` unchanged. Without the macro, `busy` stays high.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the iterative mul/div engines, applies sign fixup, owns HI/LO.
// Optional run watchdog is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        op_div,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        div_clear,
    output logic        div_start,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [2:0] {IDLE, DCLR, DRUN, MRUN, DONE} state_t;
    state_t state, state_next;
    logic s_a, s_b, clr, run_done, expired, tmo_hit;

    assign run_done = (state == DRUN && div_done) || (state == MRUN && mult_done);
    assign tmo_hit  = expired && !run_done;

`ifdef MULDIV_TIMEOUT_EN
    logic [6:0] cnt;
    logic       tmo;
    assign expired = (state == DRUN || state == MRUN) && cnt == 7'(TIMEOUT_CYCLES - 1);
    assign timeout = tmo;
    // run-cycle counter: zero on the first run cycle, counts while an engine runs
    always_ff @(posedge clock)
        if (reset || !(state == DRUN || state == MRUN)) cnt <= '0;
        else cnt <= cnt + 7'd1;
    // sticky watchdog flag, cleared by the next accepted request
    always_ff @(posedge clock)
        if (reset || (state == IDLE && req)) tmo <= 1'b0;
        else if (tmo_hit) tmo <= 1'b1;
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clock)
        if (reset) state <= IDLE;
        else state <= state_next;

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (req) state_next = !op_div ? MRUN : (rt_val == '0 ? DONE : DCLR);
            DCLR:       state_next = DRUN;
            DRUN, MRUN: if (run_done || expired) state_next = DONE;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // divider clear is registered: flushes on reset, before each divide, and after a divide watchdog trip
    always_ff @(posedge clock)
        clr <= reset || state_next == DCLR || (state == DRUN && tmo_hit);

    assign div_clear  = clr;
    assign div_start  = state == DRUN;
    assign mult_start = state == MRUN;
    assign busy       = state == DCLR || state == DRUN || state == MRUN;
    assign done       = state == DONE;

    // operand signs, divide-by-zero flag and architectural HI/LO
    always_ff @(posedge clock)
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            s_a      <= 1'b0;
            s_b      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (wr_hi) hi <= wdata;
                if (wr_lo) lo <= wdata;
                if (req) begin
                    s_a      <= rs_val[31];
                    s_b      <= rt_val[31];
                    div_zero <= op_div && rt_val == '0;
                end
            end
            if (state == DRUN && div_done) begin
                lo <= (s_a ^ s_b) ? -div_quot : div_quot;
                hi <= s_a ? -div_rem : div_rem;
            end
            if (state == MRUN && mult_done) begin
                hi <= mult_hi;
                lo <= mult_lo;
            end
        end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random checks of muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;
    logic clock = 0, reset = 1, req = 0, op_div = 0, wr_hi = 0, wr_lo = 0;
    logic hang = 0, fixed = 0;
    logic [31:0] rs_val = 0, rt_val = 0, wdata = 0, cur_a = 0, cur_b = 0;
    logic div_clear, div_start, div_done, mult_start, mult_done, busy, done, div_zero, timeout;
    logic [31:0] div_quot, div_rem, mult_hi, mult_lo, hi, lo;
    logic [31:0] m_hi = 0, m_lo = 0;
    int dcnt = 0, mcnt = 0, checks = 0, failures = 0;

    muldiv_ctrl dut (
        .clock(clock), .reset(reset), .req(req), .op_div(op_div),
        .rs_val(rs_val), .rt_val(rt_val), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .div_clear(div_clear), .div_start(div_start), .div_done(div_done),
        .div_quot(div_quot), .div_rem(div_rem), .mult_start(mult_start),
        .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mag(input logic [31:0] x);
        return x[31] ? -x : x;
    endfunction

    // engine models: divider finishes in its 34th start cycle, multiplier in its 5th
    always @(posedge clock) begin
        dcnt <= div_clear ? 0 : div_start ? dcnt + 1 : dcnt;
        mcnt <= mult_start ? mcnt + 1 : 0;
    end
    assign div_done  = div_start && dcnt == 33 && !hang;
    assign div_quot  = cur_b == 0 ? 32'd0 : mag(cur_a) / mag(cur_b);
    assign div_rem   = cur_b == 0 ? 32'd0 : mag(cur_a) % mag(cur_b);
    assign mult_done = mult_start && mcnt == 4;
    assign {mult_hi, mult_lo} = fixed ? 64'hFFFFFFFF_FFFFFFFA
                                      : 64'(longint'($signed(cur_a)) * longint'($signed(cur_b)));

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bc, output logic c1, output logic eng);
        cur_a = a; cur_b = b;
        req = 1; op_div = op; rs_val = a; rt_val = b;
        @(posedge clock); #1;
        req = 0; wr_hi = 0; wr_lo = 0; rs_val = $urandom; rt_val = $urandom;
        lat = 1; bc = 0; c1 = div_clear; eng = div_clear | div_start;
        while (!done && lat < 200) begin
            bc += int'(busy);
            @(posedge clock); #1;
            lat++;
            eng |= div_clear | div_start;
        end
    endtask

    task automatic op_check(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b);
        int lat, bc;
        logic c1, eng, dz;
        logic [63:0] r;
        dz = op && b == 0;
        run_op(op, a, b, lat, bc, c1, eng);
        if (!op) begin
            r = 64'(longint'($signed(a)) * longint'($signed(b)));
            {m_hi, m_lo} = fixed ? 64'hFFFFFFFF_FFFFFFFA : r;
        end else if (!dz) {m_hi, m_lo} = ref_div(a, b);
        chk({tag, " latency"}, lat, dz ? 1 : op ? 36 : 6);
        chk({tag, " busy_cycles"}, bc, dz ? 0 : op ? 35 : 5);
        chk({tag, " clear_t1"}, c1, op && !dz);
        chk({tag, " hilo"}, {hi, lo}, {m_hi, m_lo});
        chk({tag, " flags_at_done"}, {busy, div_start, mult_start, div_zero, timeout}, {4'b0000, dz, 1'b0});
        if (dz) chk({tag, " no_engine"}, eng, 0);
        @(posedge clock); #1;
        chk({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        int lat, bc;
        logic c1, eng;
        logic [31:0] a, b, d;
        @(posedge clock); #1;
        chk("reset_outputs", {div_clear, div_start, mult_start, busy, done, div_zero, timeout, hi, lo},
            {7'b1000000, 64'd0});
        reset = 0;
        @(posedge clock); #1;
        chk("clear_after_reset", div_clear, 0);
        wr_hi = 1; wdata = 32'h1234; @(posedge clock); #1;
        wr_hi = 0; wr_lo = 1; wdata = 32'h5678; @(posedge clock); #1;
        wr_lo = 0; m_hi = 32'h1234; m_lo = 32'h5678;
        chk("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});

        op_check("div_m7_2", 1, -32'sd7, 32'd2);
        chk("div_m7_2_exact", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        op_check("div_ovf", 1, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_exact", {hi, lo}, {32'h0, 32'h80000000});
        op_check("div_zero", 1, 32'd100, 32'd0);
        wr_lo = 1; wdata = 32'hCAFE0001; m_lo = 32'hCAFE0001;
        op_check("div_zero_with_mtlo", 1, 32'd5, 32'd0);

        fixed = 1;
        cur_a = 32'd3; cur_b = 32'd7;
        req = 1; op_div = 0; rs_val = 3; rt_val = 7;
        @(posedge clock); #1;
        req = 0; @(posedge clock); #1;
        wr_hi = 1; wdata = 32'hDEAD; @(posedge clock); #1;
        wr_hi = 0;
        chk("mthi_while_busy", {busy, hi}, {1'b1, m_hi});
        for (int i = 0; i < 10 && !done; i++) begin @(posedge clock); #1; end
        chk("mult_stub", {done, hi, lo}, {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA});
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFA;
        @(posedge clock); #1;
        op_check("mult_stub_full", 0, 32'd11, 32'd13);
        fixed = 0;

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom;
                if ($urandom_range(0, 1) == 1) begin wr_hi = 1; m_hi = d; end
                else begin wr_lo = 1; m_lo = d; end
                wdata = d; @(posedge clock); #1;
                wr_hi = 0; wr_lo = 0;
            end
            a = $urandom;
            b = $urandom_range(0, 4) == 0 ? 32'd0 : $urandom_range(0, 1) == 1 ? $urandom : $urandom_range(1, 40);
            op_check($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, b);
        end

        cur_a = 100; cur_b = 7;
        req = 1; op_div = 1; rs_val = 100; rt_val = 7;
        @(posedge clock); #1;
        req = 0;
        repeat (10) begin @(posedge clock); #1; end
        chk("mid_drun_busy", {busy, div_start}, 2'b11);
        reset = 1; @(posedge clock); #1;
        reset = 0; m_hi = 0; m_lo = 0;
        chk("reset_mid_drun", {div_clear, busy, div_start, done, hi, lo}, {4'b1000, 64'd0});
        @(posedge clock); #1;
        op_check("div_9_3", 1, 32'd9, 32'd3);
        chk("div_9_3_exact", {hi, lo}, {32'd0, 32'd3});

        hang = 1;
        run_op(1, 32'd50, 32'd5, lat, bc, c1, eng);
`ifdef MULDIV_TIMEOUT_EN
        chk("tmo_latency", lat, 66);
        chk("tmo_flags", {done, timeout, busy, div_start, div_clear, hi, lo}, {5'b11001, m_hi, m_lo});
`else
        chk("hang_busy", {done, busy, timeout, div_start}, 4'b0101);
`endif
        hang = 0;
        reset = 1; @(posedge clock); #1;
        reset = 0; m_hi = 0; m_lo = 0;
        @(posedge clock); #1;
        op_check("post_hang_mult", 0, -32'sd6, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
